// File: rtl/seqdet_word_ctrl.sv
// seqdet_word_ctrl: word-to-serial sequencer for the 10010 pattern detector.
// Optional hit/word statistics enabled by `define SEQDET_WORD_CTRL_STAT_EN.
module seqdet_word_ctrl #(
   parameter int W     = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
`ifdef SEQDET_WORD_CTRL_STAT_EN
   input  logic             stat_clr,
   output logic [15:0]      stat_words,
   output logic [15:0]      stat_hits,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   output logic             ser_x,
   output logic             det_rst_n,
   input  logic             det_z,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_hits,
   output logic [CNT_W-1:0] out_count,
   output logic             busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [W-1:0]     r_shreg;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [W-1:0]     r_hits;
   logic [CNT_W-1:0] r_cnt;
   logic [W-1:0]     r_out_hits;
   logic [CNT_W-1:0] r_out_count;
   logic             r_out_valid;
   logic             r_det_rst_n;
   logic [W-1:0]     w_hit_mask;
   logic [W-1:0]     w_hits_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_last;

   assign w_last     = (r_bit_cnt == '0);
   assign w_hit_mask = det_z ? (W'(1) << r_bit_cnt) : '0;
   assign w_hits_nxt = r_hits | w_hit_mask;
   assign w_cnt_nxt  = r_cnt + {{(CNT_W-1){1'b0}}, det_z};

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign ser_x     = (r_state == S_SHIFT) & r_shreg[W-1];
   assign det_rst_n = r_det_rst_n;
   assign out_valid = r_out_valid;
   assign out_hits  = r_out_hits;
   assign out_count = r_out_count;

   // next-state decode: accept, shift W bits, wait for result handshake
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (in_valid)  w_state_nxt = S_SHIFT;
         S_SHIFT: if (w_last)    w_state_nxt = S_RESP;
         S_RESP:  if (out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // datapath: load word, shift MSB-first, accumulate hits, publish result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_shreg     <= '0;
         r_bit_cnt   <= '0;
         r_hits      <= '0;
         r_cnt       <= '0;
         r_out_hits  <= '0;
         r_out_count <= '0;
         r_out_valid <= 1'b0;
         r_det_rst_n <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_det_rst_n <= (w_state_nxt == S_SHIFT);
         unique case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_shreg   <= in_data;
                  r_bit_cnt <= CNT_W'(W-1);
                  r_hits    <= '0;
                  r_cnt     <= '0;
               end
            end
            S_SHIFT: begin
               r_shreg <= {r_shreg[W-2:0], 1'b0};
               r_hits  <= w_hits_nxt;
               r_cnt   <= w_cnt_nxt;
               if (!w_last) r_bit_cnt <= r_bit_cnt - 1'b1;
               if (w_last) begin
                  r_out_hits  <= w_hits_nxt;
                  r_out_count <= w_cnt_nxt;
                  r_out_valid <= 1'b1;
               end
            end
            S_RESP: begin
               if (out_ready) r_out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef SEQDET_WORD_CTRL_STAT_EN
   logic [15:0] r_stat_words;
   logic [15:0] r_stat_hits;
   logic        w_hs;
   logic [16:0] w_hits_sum;

   assign w_hs       = r_out_valid & out_ready;
   assign w_hits_sum = {1'b0, r_stat_hits} + 17'(r_out_count);
   assign stat_words = r_stat_words;
   assign stat_hits  = r_stat_hits;

   // saturating statistics; a clear beats a coincident handshake
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stat_words <= '0;
         r_stat_hits  <= '0;
      end else if (stat_clr) begin
         r_stat_words <= '0;
         r_stat_hits  <= '0;
      end else if (w_hs) begin
         if (r_stat_words != 16'hFFFF) r_stat_words <= r_stat_words + 16'd1;
         r_stat_hits <= w_hits_sum[16] ? 16'hFFFF : w_hits_sum[15:0];
      end
   end
`endif

endmodule

// File: tb/tb_seqdet_word_ctrl.sv
// tb_seqdet_word_ctrl: scoreboard bench for seqdet_word_ctrl.
// Contains a behavioural 10010 overlapping Mealy detector on the serial side.
module tb_seqdet_word_ctrl;

   localparam int W     = 8;
   localparam int CNT_W = 4;

   typedef struct packed {
      logic [W-1:0]     hits;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     in_data = '0;
   logic             ser_x;
   logic             det_rst_n;
   logic             det_z;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [W-1:0]     out_hits;
   logic [CNT_W-1:0] out_count;
   logic             busy;
`ifdef SEQDET_WORD_CTRL_STAT_EN
   logic             stat_clr = 1'b0;
   logic [15:0]      stat_words;
   logic [15:0]      stat_hits;
`endif

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_res  = 0;
   int   n_push = 0;

   seqdet_word_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef SEQDET_WORD_CTRL_STAT_EN
      .stat_clr  (stat_clr),
      .stat_words(stat_words),
      .stat_hits (stat_hits),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .ser_x     (ser_x),
      .det_rst_n (det_rst_n),
      .det_z     (det_z),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_hits  (out_hits),
      .out_count (out_count),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // serial detector: last four bits plus fill level, z when 1001 then x=0
   logic [3:0] d_hist;
   logic [2:0] d_len;
   always @(posedge clk or negedge det_rst_n) begin
      if (!det_rst_n) begin
         d_hist <= '0;
         d_len  <= '0;
      end else begin
         d_hist <= {d_hist[2:0], ser_x};
         if (d_len < 3'd4) d_len <= d_len + 3'd1;
      end
   end
   assign det_z = det_rst_n && (d_len >= 3'd4) &&
                  (d_hist == 4'b1001) && !ser_x;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic exp_t ref_scan(input logic [W-1:0] d);
      logic [4:0] win;
      int         seen;
      exp_t       e;
      win  = '0;
      seen = 0;
      e    = '0;
      for (int i = W-1; i >= 0; i--) begin
         win = {win[3:0], d[i]};
         seen++;
         if (seen >= 5 && win == 5'b10010) begin
            e.hits[i] = 1'b1;
            e.cnt     = e.cnt + 1'b1;
         end
      end
      return e;
   endfunction

   task automatic push_exp(input logic [W-1:0] d);
      sb_q.push_back(ref_scan(d));
      n_push++;
   endtask

   // result monitor: compare at every handshake
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
         else begin
            mon_e = sb_q.pop_front();
            chk("hits", out_hits, mon_e.hits);
            chk("count", out_count, mon_e.cnt);
            n_res++;
         end
      end
   end

   // caller is #1 after a rising edge
   task automatic send(input logic [W-1:0] d, input bit push);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) chk("send_timeout", 0, 1);
      else if (push) push_exp(d);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge clk);
      while (!(in_ready && !out_valid) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("idle_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic wait_ov();
      int t;
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!out_valid) chk("ov_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc1, acc2, cyc;

      // reset values
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_hits", out_hits, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_ser_x", ser_x, 0);
      chk("rst_det_rst_n", det_rst_n, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // basic match with latency
      in_valid = 1'b1;
      in_data  = 8'b1001_0010;
      @(negedge clk);
      chk("acc_in_ready", in_ready, 1);
      push_exp(in_data);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         chk("shift_det_rst_n", det_rst_n, 1);
         chk("shift_out_valid", out_valid, 0);
         if (i == 0) chk("shift_in_ready", in_ready, 0);
      end
      @(negedge clk);
      chk("lat_out_valid", out_valid, 1);
      chk("resp_det_rst_n", det_rst_n, 0);
      chk("resp_busy", busy, 1);
      wait_idle();

      // single match and no-match words
      send(8'b0100_1000, 1);
      wait_idle();
      send(8'h00, 1);
      wait_idle();
`ifdef SEQDET_WORD_CTRL_STAT_EN
      @(negedge clk);
      chk("stat_words3", stat_words, 3);
      chk("stat_hits3", stat_hits, 3);
      @(posedge clk); #1;
`endif
      send(8'hFF, 1);
      wait_idle();

      // backpressure: result held, new words ignored
      out_ready = 1'b0;
      send(8'b1001_0010, 1);
      wait_ov();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 8'b0100_1000;
         @(negedge clk);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_out_hits", out_hits, 8'b0000_1001);
         chk("bp_out_count", out_count, 2);
         chk("bp_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_idle_in_ready", in_ready, 1);
      chk("bp_idle_out_valid", out_valid, 0);
      chk("bp_hold_hits", out_hits, 8'b0000_1001);
      @(posedge clk); #1;

      // back-to-back with in_valid held
      acc1 = -1;
      acc2 = -1;
      cyc  = 0;
      in_valid = 1'b1;
      in_data  = 8'b1001_0010;
      while (acc2 < 0 && cyc < 100) begin
         @(negedge clk);
         if (in_ready) begin
            if (acc1 < 0) begin
               acc1 = cyc;
               push_exp(in_data);
            end else begin
               acc2 = cyc;
               push_exp(in_data);
            end
         end
         @(posedge clk); #1;
         if (acc1 >= 0 && acc2 < 0) in_data = 8'b0100_1000;
         if (acc2 >= 0) in_valid = 1'b0;
         cyc++;
      end
      in_valid = 1'b0;
      chk("b2b_gap", acc2 - acc1, W + 2);
      wait_idle();

      // asynchronous reset in the 4th shift cycle
      send(8'b1001_0010, 0);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_det_rst_n", det_rst_n, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      send(8'b1001_0010, 1);
      wait_idle();

`ifdef SEQDET_WORD_CTRL_STAT_EN
      // clear coinciding with a handshake
      out_ready = 1'b0;
      send(8'b1001_0010, 1);
      wait_ov();
      out_ready = 1'b1;
      stat_clr  = 1'b1;
      @(posedge clk); #1;
      stat_clr  = 1'b0;
      chk("stat_clr_words", stat_words, 0);
      chk("stat_clr_hits", stat_hits, 0);
      wait_idle();
`endif

      chk("sb_empty", sb_q.size(), 0);
      chk("n_results", n_res, n_push);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
